// File: rtl/chroma_key_blend.sv
// Chroma-key blender: selects a key channel, derives a soft-edge alpha from the key excess
// and mixes foreground with background over a fixed 3-stage pipeline, counting keyed pixels per frame.
module chroma_key_blend #(
  parameter int             DW         = 10,
  parameter int             AW         = 4,
  parameter int             KEY_CH     = 1,
  parameter int             SOFT_SHIFT = 3,
  parameter int             CW         = 22,
  parameter logic [DW-1:0]  TLO_RST    = 10'h080,
  parameter logic [DW-1:0]  KMIN_RST   = 10'h100
) (
  input  logic          iCLK27,
  input  logic          iRST_N,
  input  logic          iValid,
  input  logic          iSOF,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [DW-1:0] imVGA_R,
  input  logic [DW-1:0] imVGA_G,
  input  logic [DW-1:0] imVGA_B,
  input  logic          iBypass,
  input  logic          iCfgWe,
  input  logic [DW-1:0] iTlo,
  input  logic [DW-1:0] iKeyMin,
  output logic          oValid,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic [AW:0]   oAlpha,
  output logic [CW-1:0] oKeyCount
);

  localparam int             PW      = DW + AW + 1;
  localparam int             OA      = (KEY_CH + 1) % 3;
  localparam int             OB      = (KEY_CH + 2) % 3;
  localparam logic [AW:0]    AMAX    = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0]  HALF    = PW'(1) << (AW - 1);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  logic [DW-1:0] fg_in   [3];
  logic [DW-1:0] bg_in   [3];
  logic [DW-1:0] out_pix [3];

  assign fg_in[0] = iRed;
  assign fg_in[1] = iGreen;
  assign fg_in[2] = iBlue;
  assign bg_in[0] = imVGA_R;
  assign bg_in[1] = imVGA_G;
  assign bg_in[2] = imVGA_B;

  // ---------------------------------------------------------------- config
  logic [DW-1:0] shd_tlo_reg, shd_kmin_reg;
  logic [DW-1:0] act_tlo_reg, act_kmin_reg;

  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      shd_tlo_reg  <= TLO_RST;
      shd_kmin_reg <= KMIN_RST;
      act_tlo_reg  <= TLO_RST;
      act_kmin_reg <= KMIN_RST;
    end else begin
      if (iCfgWe) begin
        shd_tlo_reg  <= iTlo;
        shd_kmin_reg <= iKeyMin;
      end
      // A write landing on the SOF pixel bypasses the shadow so it is not lost for a frame.
      if (iSOF && iValid) begin
        act_tlo_reg  <= iCfgWe ? iTlo    : shd_tlo_reg;
        act_kmin_reg <= iCfgWe ? iKeyMin : shd_kmin_reg;
      end
    end
  end

  // ---------------------------------------------------------------- S1: key / diff
  logic [DW-1:0]        key_val, oth_max;
  logic signed [DW:0]   diff_val;

  assign key_val  = fg_in[KEY_CH];
  assign oth_max  = (fg_in[OA] > fg_in[OB]) ? fg_in[OA] : fg_in[OB];
  assign diff_val = $signed({1'b0, key_val}) - $signed({1'b0, oth_max});

  logic                 s1_valid_reg, s1_sof_reg;
  logic signed [DW:0]   s1_diff_reg;
  logic [DW-1:0]        s1_key_reg, s1_tlo_reg, s1_kmin_reg;

  // Thresholds travel with the pixel so the SOF pixel sees the values active before its own update.
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_diff_reg  <= '0;
      s1_key_reg   <= '0;
      s1_tlo_reg   <= '0;
      s1_kmin_reg  <= '0;
    end else begin
      s1_valid_reg <= iValid;
      s1_sof_reg   <= iSOF;
      s1_diff_reg  <= diff_val;
      s1_key_reg   <= key_val;
      s1_tlo_reg   <= act_tlo_reg;
      s1_kmin_reg  <= act_kmin_reg;
    end
  end

  // ---------------------------------------------------------------- S2: alpha
  logic [DW+1:0] excess, ramp;
  logic [AW:0]   alpha_next;

  assign excess = {s1_diff_reg[DW], s1_diff_reg} - {2'b00, s1_tlo_reg};
  assign ramp   = excess >> SOFT_SHIFT;

  always_comb begin
    alpha_next = '0;
    if (iBypass || (s1_key_reg < s1_kmin_reg) ||
        (s1_diff_reg <= $signed({1'b0, s1_tlo_reg}))) begin
      alpha_next = '0;
    end else if (ramp >= (DW+2)'(AMAX)) begin
      alpha_next = AMAX;
    end else begin
      alpha_next = ramp[AW:0];
    end
  end

  logic          s2_valid_reg, s2_sof_reg;
  logic [AW:0]   s2_alpha_reg;

  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      s2_valid_reg <= 1'b0;
      s2_sof_reg   <= 1'b0;
      s2_alpha_reg <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_sof_reg   <= s1_sof_reg;
      s2_alpha_reg <= alpha_next;
    end
  end

  // ---------------------------------------------------------------- per-channel datapath
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [DW-1:0] s1_fg_reg, s1_bg_reg;
      logic [DW-1:0] s2_fg_reg, s2_bg_reg;
      logic [DW-1:0] pix_reg;
      logic [PW-1:0] mix;

      // Sum stays below 2^(DW+AW), so the shifted result always fits DW bits.
      assign mix = PW'(s2_fg_reg) * PW'(AMAX - s2_alpha_reg)
                 + PW'(s2_bg_reg) * PW'(s2_alpha_reg)
                 + HALF;

      always_ff @(posedge iCLK27 or negedge iRST_N) begin
        if (!iRST_N) begin
          s1_fg_reg <= '0;
          s1_bg_reg <= '0;
          s2_fg_reg <= '0;
          s2_bg_reg <= '0;
          pix_reg   <= '0;
        end else begin
          s1_fg_reg <= fg_in[gi];
          s1_bg_reg <= bg_in[gi];
          s2_fg_reg <= s1_fg_reg;
          s2_bg_reg <= s1_bg_reg;
          if (s2_valid_reg) pix_reg <= DW'(mix >> AW);
        end
      end

      assign out_pix[gi] = pix_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- S3: outputs and counter
  logic          out_valid_reg;
  logic [AW:0]   out_alpha_reg;
  logic [CW-1:0] run_cnt_reg, key_cnt_reg;
  logic          full_key;

  assign full_key = (s2_alpha_reg == AMAX);

  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      out_valid_reg <= 1'b0;
      out_alpha_reg <= '0;
      run_cnt_reg   <= '0;
      key_cnt_reg   <= '0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_alpha_reg <= s2_alpha_reg;
        if (s2_sof_reg) begin
          key_cnt_reg <= run_cnt_reg;
          run_cnt_reg <= full_key ? CW'(1) : '0;
        end else if (full_key && (run_cnt_reg != CNT_MAX)) begin
          run_cnt_reg <= run_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign oValid    = out_valid_reg;
  assign oRed      = out_pix[0];
  assign oGreen    = out_pix[1];
  assign oBlue     = out_pix[2];
  assign oAlpha    = out_alpha_reg;
  assign oKeyCount = key_cnt_reg;

endmodule

// File: tb/tb_chroma_key_blend.sv
// Bench for chroma_key_blend: vector table plus hand-built frame sequences,
// with expected pixels queued at drive time and checked when oValid emerges.
module tb_chroma_key_blend;

  logic        clk = 1'b0;
  logic        iRST_N;
  logic        iValid, iSOF, iBypass, iCfgWe;
  logic [9:0]  iRed, iGreen, iBlue, imVGA_R, imVGA_G, imVGA_B, iTlo, iKeyMin;
  logic        oValid;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [4:0]  oAlpha;
  logic [21:0] oKeyCount;

  chroma_key_blend dut (
    .iCLK27(clk), .iRST_N(iRST_N), .iValid(iValid), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .imVGA_R(imVGA_R), .imVGA_G(imVGA_G), .imVGA_B(imVGA_B),
    .iBypass(iBypass), .iCfgWe(iCfgWe), .iTlo(iTlo), .iKeyMin(iKeyMin),
    .oValid(oValid), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oAlpha(oAlpha), .oKeyCount(oKeyCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [29:0] fg;
    logic [29:0] bg;
    logic        byp;
    logic [29:0] eo;
    logic [4:0]  ea;
  } vec_t;

  typedef struct {
    logic [29:0] eo;
    logic [4:0]  ea;
    int          cyc;
    logic        chk_kc;
    logic [21:0] kc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic pend_byp = 1'b0;

  localparam logic [29:0] K_FG = {10'd100, 10'd800, 10'd100};
  localparam logic [29:0] K_BG = {10'd900, 10'd0,   10'd500};
  localparam logic [29:0] N_FG = {10'd500, 10'd520, 10'd100};
  localparam logic [29:0] N_BG = {10'd1,   10'd2,   10'd3};
  localparam logic [29:0] S_FG = {10'd100, 10'd300, 10'd100};
  localparam logic [29:0] S_BG = {10'd900, 10'd900, 10'd900};
  localparam logic [29:0] S9   = {10'd550, 10'd638, 10'd550};
  localparam logic [29:0] S6   = {10'd400, 10'd525, 10'd400};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic logic [29:0] rgb(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic vec_t mk(input logic [29:0] fg, input logic [29:0] bg, input logic byp,
                              input logic [29:0] eo, input int ea);
    vec_t v;
    v.fg = fg; v.bg = bg; v.byp = byp; v.eo = eo; v.ea = 5'(ea);
    return v;
  endfunction

  // iBypass is consumed one cycle after the pixel is driven, so it lags the pixel here.
  task automatic drive(input logic v, input logic sof, input logic [29:0] fg, input logic [29:0] bg,
                       input logic byp, input logic we, input logic [9:0] tlo, input logic [9:0] kmin);
    iValid = v; iSOF = sof;
    iRed = fg[29:20]; iGreen = fg[19:10]; iBlue = fg[9:0];
    imVGA_R = bg[29:20]; imVGA_G = bg[19:10]; imVGA_B = bg[9:0];
    iBypass = pend_byp;
    pend_byp = v ? byp : 1'b0;
    iCfgWe = we; iTlo = tlo; iKeyMin = kmin;
    @(negedge clk);
  endtask

  task automatic idle(input logic we = 1'b0, input logic [9:0] tlo = '0, input logic [9:0] kmin = '0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, we, tlo, kmin);
  endtask

  task automatic pix(input logic [29:0] fg, input logic [29:0] bg, input logic byp, input logic sof,
                     input logic [29:0] eo, input int ea, input logic ck = 1'b0, input int kc = 0,
                     input logic we = 1'b0, input logic [9:0] tlo = '0, input logic [9:0] kmin = '0);
    exp_t e;
    e.eo = eo; e.ea = 5'(ea); e.cyc = cyc + 3; e.chk_kc = ck; e.kc = 22'(kc);
    sb.push_back(e);
    drive(1'b1, sof, fg, bg, byp, we, tlo, kmin);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    idle();
    idle();
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (iRST_N === 1'b1 && oValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out rgb=(%0d,%0d,%0d) alpha=%0d cyc=%0d kc=%0d", oRed, oGreen, oBlue, oAlpha, cyc, oKeyCount);
        check("pix_rgb", 64'({oRed, oGreen, oBlue}), 64'(e.eo));
        check("alpha", 64'(oAlpha), 64'(e.ea));
        check("latency", 64'(cyc), 64'(e.cyc));
        if (e.chk_kc) check("keycount", 64'(oKeyCount), 64'(e.kc));
      end
    end
  end

  vec_t tbl[12];

  initial begin
    iRST_N = 1'b0;
    iValid = 0; iSOF = 0; iBypass = 0; iCfgWe = 0;
    iRed = 0; iGreen = 0; iBlue = 0; imVGA_R = 0; imVGA_G = 0; imVGA_B = 0;
    iTlo = 0; iKeyMin = 0;

    // Defaults: Tlo=128, KeyMin=256, ramp step 8 codes per alpha LSB.
    tbl[0]  = mk(K_FG, K_BG, 1'b0, K_BG, 16);
    tbl[1]  = mk(N_FG, N_BG, 1'b0, N_FG, 0);
    tbl[2]  = mk(rgb(50, 200, 50), rgb(1000, 1000, 1000), 1'b0, rgb(50, 200, 50), 0);
    tbl[3]  = mk(S_FG, S_BG, 1'b0, S9, 9);
    tbl[4]  = mk(rgb(0, 384, 256), rgb(1023, 1023, 1023), 1'b0, rgb(0, 384, 256), 0);
    tbl[5]  = mk(rgb(0, 392, 256), rgb(1023, 1023, 1023), 1'b0, rgb(64, 431, 304), 1);
    tbl[6]  = mk(rgb(0, 512, 256), rgb(7, 8, 9), 1'b0, rgb(7, 8, 9), 16);
    tbl[7]  = mk(rgb(0, 511, 256), rgb(0, 0, 0), 1'b0, rgb(0, 32, 16), 15);
    tbl[8]  = mk(rgb(900, 300, 100), rgb(5, 5, 5), 1'b0, rgb(900, 300, 100), 0);
    tbl[9]  = mk(rgb(0, 256, 0), rgb(11, 22, 33), 1'b0, rgb(11, 22, 33), 16);
    tbl[10] = mk(K_FG, K_BG, 1'b1, K_FG, 0);
    tbl[11] = mk(rgb(0, 448, 256), rgb(1023, 0, 1), 1'b0, rgb(512, 224, 129), 8);

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_rgb", 64'({oRed, oGreen, oBlue}), 64'd0);
    check("rst_alpha", 64'(oAlpha), 64'd0);
    check("rst_keycount", 64'(oKeyCount), 64'd0);
    iRST_N = 1'b1;

    // Vector table with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      pix(tbl[i].fg, tbl[i].bg, tbl[i].byp, 1'b0, tbl[i].eo, int'(tbl[i].ea));
    end
    drain();

    // Soft edge: Tlo=150/KeyMin=0 staged, SOF pixel still uses defaults, next one uses new values.
    idle(1'b1, 10'd150, 10'd0);
    pix(S_FG, S_BG, 1'b0, 1'b1, S9, 9, 1'b1, 3);
    pix(S_FG, S_BG, 1'b0, 1'b0, S6, 6);

    // Mid-frame write of Tlo=1000 only takes hold after the next SOF pixel.
    idle(1'b1, 10'd1000, 10'd0);
    pix(S_FG, S_BG, 1'b0, 1'b0, S6, 6);
    pix(S_FG, S_BG, 1'b0, 1'b1, S6, 6, 1'b1, 0);
    pix(S_FG, S_BG, 1'b0, 1'b0, S_FG, 0);
    // Write coinciding with SOF: SOF pixel keeps Tlo=1000, following pixel sees Tlo=150.
    pix(S_FG, S_BG, 1'b0, 1'b1, S_FG, 0, 1'b1, 0, 1'b1, 10'd150, 10'd0);
    pix(S_FG, S_BG, 1'b0, 1'b0, S6, 6);
    drain();

    // Frame of 10 valid pixels, 4 fully keyed (including the SOF pixel), with gaps.
    pix(K_FG, K_BG, 1'b0, 1'b1, K_BG, 16, 1'b1, 0);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    idle();
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    idle();
    idle();
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    idle();
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    pix(N_FG, N_BG, 1'b0, 1'b0, N_FG, 0);
    // Next frame fully bypassed.
    pix(N_FG, N_BG, 1'b1, 1'b1, N_FG, 0, 1'b1, 4);
    pix(K_FG, K_BG, 1'b1, 1'b0, K_FG, 0);
    idle();
    pix(K_FG, K_BG, 1'b1, 1'b0, K_FG, 0);
    pix(K_FG, K_BG, 1'b1, 1'b0, K_FG, 0);
    pix(N_FG, N_BG, 1'b0, 1'b1, N_FG, 0, 1'b1, 0);
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(N_FG, N_BG, 1'b0, 1'b1, N_FG, 0, 1'b1, 2);
    drain();

    // Asynchronous reset mid-stream with pixels in flight.
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    pix(K_FG, K_BG, 1'b0, 1'b0, K_BG, 16);
    #2 iRST_N = 1'b0;
    #1;
    check("mid_rst_valid", 64'(oValid), 64'd0);
    check("mid_rst_rgb", 64'({oRed, oGreen, oBlue}), 64'd0);
    check("mid_rst_alpha", 64'(oAlpha), 64'd0);
    check("mid_rst_keycount", 64'(oKeyCount), 64'd0);
    sb.delete();
    pend_byp = 1'b0;
    @(negedge clk);
    idle();
    iRST_N = 1'b1;
    // Config is back to defaults, so this pixel ramps to alpha 9 rather than 6.
    pix(S_FG, S_BG, 1'b0, 1'b0, S9, 9);
    pix(K_FG, K_BG, 1'b0, 1'b1, K_BG, 16, 1'b1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
